// File: rtl/quad_gen.sv
// Quadrature A/B edge generator: emits a commanded number of edges in a chosen
// direction at a programmable per-edge period, tracking its own signed position.
module quad_gen #(
  parameter int CNT_W = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] steps,
  input  logic [DIV_W-1:0] period,
  input  logic             stop,
  output logic             busy,
  output logic             done,
  output logic             a,
  output logic             b,
  output logic [CNT_W-1:0] pos
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic             run_dir, run_dir_next;
  logic [CNT_W-1:0] remaining, remaining_next;
  logic [DIV_W-1:0] period_m1, period_m1_next;
  logic [DIV_W-1:0] divider, divider_next;
  logic             busy_next, done_next, a_next, b_next;
  logic [CNT_W-1:0] pos_next;
  logic             toggle_a;

  // Right steps toggle A when A==B, left steps toggle A when A!=B; B otherwise.
  assign toggle_a = ((a ~^ b) ~^ run_dir);

  always_comb begin
    state_next     = state;
    run_dir_next   = run_dir;
    remaining_next = remaining;
    period_m1_next = period_m1;
    divider_next   = divider;
    busy_next      = busy;
    done_next      = 1'b0;
    a_next         = a;
    b_next         = b;
    pos_next       = pos;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          if (steps != '0) begin
            state_next     = RUN;
            busy_next      = 1'b1;
            run_dir_next   = dir;
            remaining_next = steps;
            period_m1_next = (period == '0) ? '0 : period - 1'b1;
            divider_next   = '0;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_next = IDLE;
          busy_next  = 1'b0;
        end else if (divider == period_m1) begin
          divider_next   = '0;
          a_next         = a ^ toggle_a;
          b_next         = b ^ ~toggle_a;
          pos_next       = run_dir ? pos + 1'b1 : pos - 1'b1;
          remaining_next = remaining - 1'b1;
          // Final edge, done and busy release land on the same clock.
          if (remaining == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state_next = IDLE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end
        end else begin
          divider_next = divider + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      run_dir   <= 1'b0;
      remaining <= '0;
      period_m1 <= '0;
      divider   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      a         <= 1'b0;
      b         <= 1'b0;
      pos       <= '0;
    end else begin
      state     <= state_next;
      run_dir   <= run_dir_next;
      remaining <= remaining_next;
      period_m1 <= period_m1_next;
      divider   <= divider_next;
      busy      <= busy_next;
      done      <= done_next;
      a         <= a_next;
      b         <= b_next;
      pos       <= pos_next;
    end
  end

endmodule

// File: tb/tb_quad_gen.sv
// Self-checking bench for quad_gen: a phase-index/position reference model and a
// bench-side quadrature decoder check every cycle of directed and random runs.
module tb_quad_gen;
  localparam int CNT_W = 8;
  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             dir = 1'b0;
  logic             stop = 1'b0;
  logic [CNT_W-1:0] steps = '0;
  logic [DIV_W-1:0] period = '0;
  logic             busy, done, a, b;
  logic [CNT_W-1:0] pos;

  int               vectors = 0;
  int               miscompares = 0;

  // Reference model: phase index 0..3 over the right-going sequence 00,10,11,01.
  int               exp_idx = 0;
  logic [CNT_W-1:0] exp_pos = '0;
  logic             exp_busy = 1'b0;
  logic             exp_done = 1'b0;
  logic [1:0]       dec_prev = 2'b00;
  logic [CNT_W-1:0] dec_cnt = '0;

  quad_gen #(.CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .steps(steps), .period(period),
    .stop(stop), .busy(busy), .done(done), .a(a), .b(b), .pos(pos)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] ab_of(input int idx);
    case (idx % 4)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic int idx_of(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_edge(input logic d);
    exp_idx = (exp_idx + (d ? 1 : 3)) % 4;
    exp_pos = d ? exp_pos + 1'b1 : exp_pos - 1'b1;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    #2;
    rst = 1'b0;
    exp_idx = 0; exp_pos = '0; exp_busy = 1'b0; exp_done = 1'b0;
    dec_prev = 2'b00; dec_cnt = '0;
    tick();
  endtask

  // Issues one command and scrambles the inputs afterwards to prove they were latched.
  task automatic issue(input logic d, input logic [CNT_W-1:0] s, input logic [DIV_W-1:0] p);
    $display("run dir=%0d steps=%0d period=%0d from ab=%b pos=%0d", d, s, p, ab_of(exp_idx), exp_pos);
    start = 1'b1; dir = d; steps = s; period = p;
    tick();
    start = 1'b0;
    dir = 1'($urandom);
    steps = CNT_W'($urandom);
    period = DIV_W'($urandom);
    exp_busy = (s != 0);
    exp_done = (s == 0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({a, b, pos, busy, done} !== '0) begin
      miscompares++;
      $display("FAIL reset_init: got ab=%b%b pos=%0d busy=%b done=%b, want all zero", a, b, pos, busy, done);
    end
    rst = 1'b0;
    tick();
    issue(1'b1, 8'd10, 16'd2);
    for (int k = 1; k <= 5; k++) tick();
    vectors++;
    if ({a, b} !== 2'b11 || pos !== 8'd2 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_premid: got ab=%b%b pos=%0d busy=%b, want ab=11 pos=2 busy=1", a, b, pos, busy);
    end
    #3 rst = 1'b1;
    #1;
    vectors++;
    if ({a, b, pos, busy, done} !== '0) begin
      miscompares++;
      $display("FAIL reset_async: got ab=%b%b pos=%0d busy=%b done=%b, want all zero", a, b, pos, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_idx = 0; exp_pos = '0; exp_busy = 1'b0; exp_done = 1'b0;
    tick();
    tick();
    vectors++;
    if ({a, b, pos, busy, done} !== '0) begin
      miscompares++;
      $display("FAIL reset_after: got ab=%b%b pos=%0d busy=%b done=%b, want all zero", a, b, pos, busy, done);
    end
  endtask

  task automatic test_right_run();
    reset_dut();
    issue(1'b1, 8'd4, 16'd1);
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) begin
        tick();
        model_edge(1'b1);
        exp_busy = (k < 4);
        exp_done = (k == 4);
      end
      vectors++;
      if ({a, b} !== ab_of(exp_idx) || pos !== exp_pos || busy !== exp_busy || done !== exp_done) begin
        miscompares++;
        $display("FAIL right k=%0d: got ab=%b%b pos=%0d busy=%b done=%b, want ab=%b pos=%0d busy=%b done=%b",
                 k, a, b, pos, busy, done, ab_of(exp_idx), exp_pos, exp_busy, exp_done);
      end
    end
    vectors++;
    if (pos !== 8'd4) begin
      miscompares++;
      $display("FAIL right_pos: got %0d, want 4", pos);
    end
  endtask

  task automatic test_left_run();
    reset_dut();
    issue(1'b0, 8'd3, 16'd10);
    for (int k = 0; k <= 30; k++) begin
      if (k > 0) begin
        tick();
        if (k % 10 == 0) model_edge(1'b0);
        exp_busy = (k < 30);
        exp_done = (k == 30);
      end
      vectors++;
      if ({a, b} !== ab_of(exp_idx) || pos !== exp_pos || busy !== exp_busy || done !== exp_done) begin
        miscompares++;
        $display("FAIL left k=%0d: got ab=%b%b pos=%0d busy=%b done=%b, want ab=%b pos=%0d busy=%b done=%b",
                 k, a, b, pos, busy, done, ab_of(exp_idx), exp_pos, exp_busy, exp_done);
      end
    end
    vectors++;
    if (pos !== 8'd253) begin
      miscompares++;
      $display("FAIL left_pos: got %0d, want 253", pos);
    end
  endtask

  task automatic test_boundary();
    // period=0 runs exactly like period=1
    issue(1'b1, 8'd2, 16'd0);
    for (int k = 0; k <= 2; k++) begin
      if (k > 0) begin
        tick();
        model_edge(1'b1);
        exp_busy = (k < 2);
        exp_done = (k == 2);
      end
      vectors++;
      if ({a, b} !== ab_of(exp_idx) || pos !== exp_pos || busy !== exp_busy || done !== exp_done) begin
        miscompares++;
        $display("FAIL period0 k=%0d: got ab=%b%b pos=%0d busy=%b done=%b, want ab=%b pos=%0d busy=%b done=%b",
                 k, a, b, pos, busy, done, ab_of(exp_idx), exp_pos, exp_busy, exp_done);
      end
    end
    // steps=0: a lone done pulse, no motion
    issue(1'b1, 8'd0, 16'd5);
    for (int k = 0; k <= 2; k++) begin
      if (k > 0) begin
        tick();
        exp_done = 1'b0;
      end
      vectors++;
      if ({a, b} !== ab_of(exp_idx) || pos !== exp_pos || busy !== 1'b0 || done !== exp_done) begin
        miscompares++;
        $display("FAIL steps0 k=%0d: got ab=%b%b pos=%0d busy=%b done=%b, want ab=%b pos=%0d busy=0 done=%b",
                 k, a, b, pos, busy, done, ab_of(exp_idx), exp_pos, exp_done);
      end
    end
    // stop and start together in IDLE: the start is dropped
    stop = 1'b1;
    issue(1'b0, 8'd3, 16'd1);
    exp_busy = 1'b0;
    exp_done = 1'b0;
    for (int k = 0; k <= 2; k++) begin
      if (k > 0) tick();
      if (k == 1) stop = 1'b0;
      vectors++;
      if ({a, b} !== ab_of(exp_idx) || pos !== exp_pos || busy !== 1'b0 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL stop_start_idle k=%0d: got ab=%b%b pos=%0d busy=%b done=%b, want ab=%b pos=%0d busy=0 done=0",
                 k, a, b, pos, busy, done, ab_of(exp_idx), exp_pos);
      end
    end
  endtask

  task automatic test_start_ignored();
    issue(1'b1, 8'd6, 16'd3);
    for (int k = 0; k <= 18; k++) begin
      if (k > 0) begin
        if (k == 4) begin start = 1'b1; dir = 1'b0; steps = 8'd2; period = 16'd1; end
        tick();
        if (k == 4) start = 1'b0;
        if (k % 3 == 0) model_edge(1'b1);
        exp_busy = (k < 18);
        exp_done = (k == 18);
      end
      vectors++;
      if ({a, b} !== ab_of(exp_idx) || pos !== exp_pos || busy !== exp_busy || done !== exp_done) begin
        miscompares++;
        $display("FAIL start_busy k=%0d: got ab=%b%b pos=%0d busy=%b done=%b, want ab=%b pos=%0d busy=%b done=%b",
                 k, a, b, pos, busy, done, ab_of(exp_idx), exp_pos, exp_busy, exp_done);
      end
    end
  endtask

  task automatic test_stop();
    // Stop lands in the cycle the 6th edge is due; it must be suppressed.
    issue(1'b0, 8'd10, 16'd1);
    for (int k = 1; k <= 9; k++) begin
      if (k == 6) stop = 1'b1;
      tick();
      if (k >= 6) begin
        stop = 1'b0;
        exp_busy = 1'b0;
      end else begin
        model_edge(1'b0);
      end
      exp_done = 1'b0;
      vectors++;
      if ({a, b} !== ab_of(exp_idx) || pos !== exp_pos || busy !== exp_busy || done !== exp_done) begin
        miscompares++;
        $display("FAIL stop k=%0d: got ab=%b%b pos=%0d busy=%b done=%b, want ab=%b pos=%0d busy=%b done=%b",
                 k, a, b, pos, busy, done, ab_of(exp_idx), exp_pos, exp_busy, exp_done);
      end
    end
  endtask

  task automatic test_loopback();
    int di;
    reset_dut();
    for (int r = 0; r < 20; r++) begin
      logic d;
      d = (r < 10);
      issue(d, 8'd4, 16'd5);
      for (int k = 1; k <= 20; k++) begin
        tick();
        if (k % 5 == 0) model_edge(d);
        exp_busy = (k < 20);
        exp_done = (k == 20);
        di = (idx_of({a, b}) - idx_of(dec_prev) + 4) % 4;
        if (di == 1) dec_cnt = dec_cnt + 1'b1;
        else if (di == 3) dec_cnt = dec_cnt - 1'b1;
        vectors++;
        if (di == 2 || {a, b} !== ab_of(exp_idx) || pos !== exp_pos || busy !== exp_busy || done !== exp_done) begin
          miscompares++;
          $display("FAIL loop r=%0d k=%0d: got ab=%b%b (prev %b) pos=%0d busy=%b done=%b, want ab=%b pos=%0d busy=%b done=%b",
                   r, k, a, b, dec_prev, pos, busy, done, ab_of(exp_idx), exp_pos, exp_busy, exp_done);
        end
        dec_prev = {a, b};
      end
      vectors++;
      if (dec_cnt !== pos) begin
        miscompares++;
        $display("FAIL loop_decoder r=%0d: decoder count %0d, pos %0d", r, dec_cnt, pos);
      end
      if (r == 9 || r == 19) begin
        vectors++;
        if (pos !== ((r == 9) ? 8'd40 : 8'd0)) begin
          miscompares++;
          $display("FAIL loop_pos r=%0d: got %0d, want %0d", r, pos, (r == 9) ? 40 : 0);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 30; r++) begin
      logic d;
      int   s, p, eff, total, stop_k;
      d = 1'($urandom);
      s = $urandom_range(0, 7);
      p = $urandom_range(0, 4);
      eff = (p == 0) ? 1 : p;
      total = s * eff;
      stop_k = (s != 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, total) : 0;
      issue(d, CNT_W'(s), DIV_W'(p));
      for (int k = 0; k <= total; k++) begin
        if (k > 0) begin
          if (k == stop_k) stop = 1'b1;
          tick();
          stop = 1'b0;
          if (k == stop_k) begin
            exp_busy = 1'b0;
            exp_done = 1'b0;
          end else begin
            if (k % eff == 0) model_edge(d);
            exp_busy = (k < total);
            exp_done = (k == total);
          end
        end else if (s == 0) begin
          exp_done = 1'b1;
        end
        vectors++;
        if ({a, b} !== ab_of(exp_idx) || pos !== exp_pos || busy !== exp_busy || done !== exp_done) begin
          miscompares++;
          $display("FAIL random r=%0d k=%0d: got ab=%b%b pos=%0d busy=%b done=%b, want ab=%b pos=%0d busy=%b done=%b",
                   r, k, a, b, pos, busy, done, ab_of(exp_idx), exp_pos, exp_busy, exp_done);
        end
        if (k == stop_k && k > 0) break;
      end
    end
  endtask

  initial begin
    test_reset();
    test_right_run();
    test_left_run();
    test_boundary();
    test_start_ignored();
    test_stop();
    test_loopback();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/quad_gen.md
Name: quad_gen

Overview:
- Quadrature signal generator: the transmit end of the A/B quadrature interface that the `enc` decoder receives.
- On command, emits a programmed number of quadrature edges on `a`/`b` in the requested direction, at a programmable per-edge period.
- Used as a stimulus source for `enc` and as a motor/encoder emulator in system builds. It also keeps its own running position count for cross-checking against the decoder.

Parameters:
- CNT_W, 8, width of `steps` and `pos`; matches the `enc` `cnt` width.
- DIV_W, 16, width of the `period` divider.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  command strobe; sampled only when `busy`=0.
- dir  input  1  direction, latched at accepted start; 1 = right (count up), 0 = left (count down).
- steps  input  CNT_W  number of quadrature edges to emit, latched at accepted start.
- period  input  DIV_W  clocks per edge, latched at accepted start; 0 is treated as 1.
- stop  input  1  abort; synchronous, ends a run immediately.
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse on normal completion.
- a  output  1  quadrature phase A, registered.
- b  output  1  quadrature phase B, registered.
- pos  output  CNT_W  running signed edge position, modulo 2^CNT_W.

Behaviour:
- Clocking and reset:
  - Single clock `clk`; reset `rst` is asynchronous and active-high.
  - All outputs are registered.
  - Reset values: a=0, b=0, pos=0, busy=0, done=0, state=IDLE, divider=0, remaining=0.
- Phase sequence, written as (a,b):
  - Right (dir=1): 00 -> 10 -> 11 -> 01 -> 00 ...
  - Left (dir=0): 00 -> 01 -> 11 -> 10 -> 00 ...
  - Each edge changes exactly one of `a`/`b`; the two never toggle in the same cycle.
  - The phase continues from the current (a,b) value; it is never reset between runs.
- FSM has two states, IDLE and RUN.
- IDLE:
  - If start=1 and steps!=0: latch dir/steps/period, clear divider, enter RUN, set busy=1 on the next edge.
  - If start=1 and steps=0: stay IDLE, pulse done next cycle, no a/b edge.
- RUN:
  - The divider counts up each cycle.
  - When divider reaches period-1 (period 0 treated as 1), in that clock:
    - advance the phase one step in the latched dir;
    - pos +1 for right, -1 for left, wrapping mod 2^CNT_W;
    - remaining -1;
    - divider resets to 0.
  - First edge timing: a/b change exactly `period` clocks after the edge that accepted start (period=1 gives one edge every clock).
  - Completion: the final edge, done=1 and busy=0 all appear on the same clock edge; state returns to IDLE.
  - `done` is high for exactly 1 cycle.
- Back-to-back runs: start is accepted in the same cycle done is high (busy=0), giving back-to-back runs with no idle gap beyond the new period.
- start while busy=1 is ignored; latched parameters are unchanged.
- stop=1 in RUN:
  - next edge goes to IDLE, busy=0, no done pulse;
  - a/b/pos hold their last values;
  - an edge due in that same cycle is suppressed.
- stop in IDLE has no effect. stop and start together in IDLE: stop wins and the start is dropped.
- Parameter changes on `dir`/`steps`/`period` during RUN have no effect.
- Asynchronous reset mid-run immediately forces all reset values; a/b return to 00.
- `pos` wraps silently: 255+1 = 0, 0-1 = 255 for CNT_W=8.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> a=0, b=0, pos=0, busy=0, done=0 immediately, without waiting for clk.
- Right run, steps=4, period=1 -> (a,b) = 10, 11, 01, 00 on 4 consecutive clocks; pos=4; busy high for 4 cycles; done pulses with the 4th edge.
- Left run from reset, steps=3, period=10 -> (a,b) = 01, 11, 10 spaced exactly 10 clocks apart; pos=253; done once.
- Boundary commands:
  - period=0 with steps=2 -> behaves as period=1.
  - steps=0 -> done pulses 1 cycle after start, no a/b change, busy stays 0.
- Interference during RUN:
  - start pulsed mid-run with different dir/steps -> ignored; original run completes with its latched values.
  - stop mid-run after 5 of 10 edges -> busy drops, a/b/pos frozen at the 5-edge values, no done.
- Loopback to `enc`:
  - drive `enc` with 10 right runs of 4 edges, then 10 left runs of 4 edges, period=5;
  - pos=40 after the right runs, then back to 0;
  - the `enc` count tracks pos at every done.
